// File: rtl/lut_eval_seq_if.sv
// Config, evaluate and result handshakes of the programmable LUT evaluator.
// Registered result; each channel is stalled through its own valid/ready pair.
interface lut_eval_seq_if #(
  parameter int N_IN = 3
) ();
  logic            cfg_valid;
  logic            cfg_data;
  logic            cfg_ready;
  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            in_ready;
  logic            sweep_start;
  logic            out_valid;
  logic            out_ready;
  logic            out_bit;
  logic [N_IN-1:0] out_idx;
  logic            busy;
  logic            table_ok;

  modport slave (
    input  cfg_valid, cfg_data, in_valid, in_vec, sweep_start, out_ready,
    output cfg_ready, in_ready, out_valid, out_bit, out_idx, busy, table_ok
  );

  modport master (
    output cfg_valid, cfg_data, in_valid, in_vec, sweep_start, out_ready,
    input  cfg_ready, in_ready, out_valid, out_bit, out_idx, busy, table_ok
  );
endinterface

// File: rtl/lut_eval_seq.sv
// Run-time programmable N_IN-input truth table with serial load and full-table sweep.
// Latency 1 cycle to out_valid; result held while out_ready low, which also stalls new requests.
module lut_eval_seq #(
  parameter int                 N_IN       = 3,
  parameter logic [2**N_IN-1:0] INIT_TABLE = 8'hBA,
  parameter bit                 INIT_VALID = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  lut_eval_seq_if.slave bus
);
  localparam int              DEPTH   = 2**N_IN;
  localparam logic [N_IN:0]   DEPTH_C = (N_IN+1)'(DEPTH);
  localparam logic [N_IN:0]   CNT_ONE = (N_IN+1)'(1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_READY,
    ST_SWEEP
  } state_t;

  localparam state_t RST_STATE = INIT_VALID ? ST_READY : ST_EMPTY;

  state_t             state_q,     state_d;
  logic [DEPTH-1:0]   tbl_q,       tbl_d;
  logic               table_ok_q,  table_ok_d;
  logic               out_valid_q, out_valid_d;
  logic               out_bit_q,   out_bit_d;
  logic [N_IN-1:0]    out_idx_q,   out_idx_d;
  logic [N_IN:0]      load_cnt_q,  load_cnt_d;
  logic [N_IN:0]      sweep_cnt_q, sweep_cnt_d;
  logic               busy_q,      busy_d;

  logic               cfg_ready;
  logic               cfg_fire;
  logic               out_free;
  logic               in_ready;
  logic               in_fire;
  logic               sweep_go;
  logic               sweep_load;
  logic [N_IN-1:0]    rd_idx;
  logic [N_IN-1:0]    rd_pos;

  always_comb begin
    cfg_ready  = (state_q != ST_SWEEP) && !out_valid_q;
    cfg_fire   = bus.cfg_valid && cfg_ready;
    out_free   = !out_valid_q || bus.out_ready;
    in_ready   = (state_q == ST_READY) && !bus.cfg_valid && !bus.sweep_start && out_free;
    in_fire    = bus.in_valid && in_ready;
    sweep_go   = (state_q == ST_READY) && bus.sweep_start && !bus.cfg_valid;
    sweep_load = (state_q == ST_SWEEP) && out_free && (sweep_cnt_q < DEPTH_C);
    rd_idx     = sweep_load ? sweep_cnt_q[N_IN-1:0] : bus.in_vec;
    // Entry k lives at bit DEPTH-1-k, which is simply the bitwise inverse of k.
    rd_pos     = ~rd_idx;
  end

  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    table_ok_d  = table_ok_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_bit_d   = out_bit_q;
    out_idx_d   = out_idx_q;
    load_cnt_d  = load_cnt_q;
    sweep_cnt_d = sweep_cnt_q;

    if (in_fire || sweep_load) begin
      out_valid_d = 1'b1;
      out_bit_d   = tbl_q[rd_pos];
      out_idx_d   = rd_idx;
    end

    if (cfg_fire) begin
      tbl_d = {tbl_q[DEPTH-2:0], bus.cfg_data};
    end

    case (state_q)
      ST_EMPTY, ST_READY: begin
        if (cfg_fire) begin
          state_d    = ST_LOAD;
          table_ok_d = 1'b0;
          load_cnt_d = CNT_ONE;
        end else if (sweep_go) begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (cfg_fire) begin
          if ((load_cnt_q + CNT_ONE) == DEPTH_C) begin
            state_d    = ST_READY;
            table_ok_d = 1'b1;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + CNT_ONE;
          end
        end
      end
      ST_SWEEP: begin
        // The last entry is already in the output slot once the counter hits DEPTH.
        if (sweep_load) begin
          sweep_cnt_d = sweep_cnt_q + CNT_ONE;
        end else if ((sweep_cnt_q == DEPTH_C) && out_valid_q && bus.out_ready) begin
          state_d     = ST_READY;
          sweep_cnt_d = '0;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_SWEEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_STATE;
      tbl_q       <= INIT_TABLE;
      table_ok_q  <= INIT_VALID;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_idx_q   <= '0;
      load_cnt_q  <= '0;
      sweep_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      table_ok_q  <= table_ok_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_idx_q   <= out_idx_d;
      load_cnt_q  <= load_cnt_d;
      sweep_cnt_q <= sweep_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.busy      = busy_q;
  assign bus.table_ok  = table_ok_q;
endmodule

// File: tb/tb_lut_eval_seq.sv
// Directed bench for lut_eval_seq: default 3-input instance and a 4-input instance that starts empty.
module tb_lut_eval_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  lut_eval_seq_if #(.N_IN(3)) ifa ();
  lut_eval_seq_if #(.N_IN(4)) ifb ();

  lut_eval_seq #(.N_IN(3), .INIT_TABLE(8'hBA), .INIT_VALID(1'b1)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa.slave)
  );

  lut_eval_seq #(.N_IN(4), .INIT_TABLE(16'hFFFF), .INIT_VALID(1'b0)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  v3   [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
    logic        e3   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        b69  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        e_sw [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  v4   [4] = '{4'b0000, 4'b0001, 4'b1000, 4'b1111};
    logic        e4   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  hold_idx;
    logic        stalled;
    int          n;
    int          c;

    ifa.cfg_valid = 1'b0; ifa.cfg_data = 1'b0; ifa.in_valid = 1'b0; ifa.in_vec = '0;
    ifa.sweep_start = 1'b0; ifa.out_ready = 1'b1;
    ifb.cfg_valid = 1'b0; ifb.cfg_data = 1'b0; ifb.in_valid = 1'b0; ifb.in_vec = '0;
    ifb.sweep_start = 1'b0; ifb.out_ready = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick;
    tick;

    // reset state of both instances
    chk("a_rst_out_valid", 32'(ifa.out_valid), 0);
    chk("a_rst_out_bit",   32'(ifa.out_bit),   0);
    chk("a_rst_out_idx",   32'(ifa.out_idx),   0);
    chk("a_rst_table_ok",  32'(ifa.table_ok),  1);
    chk("a_rst_busy",      32'(ifa.busy),      0);
    chk("b_rst_table_ok",  32'(ifb.table_ok),  0);
    chk("b_rst_busy",      32'(ifb.busy),      0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("a_rst_cfg_ready", 32'(ifa.cfg_ready), 1);
    chk("a_rst_in_ready",  32'(ifa.in_ready),  1);
    chk("b_rst_cfg_ready", 32'(ifb.cfg_ready), 1);
    chk("b_rst_in_ready",  32'(ifb.in_ready),  0);

    // back-to-back evaluation with the reset table 8'hBA
    for (int i = 0; i < 4; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_vec   = v3[i];
      #1;
      chk("a_eval_in_ready", 32'(ifa.in_ready), 1);
      tick;
      chk("a_eval_valid", 32'(ifa.out_valid), 1);
      chk("a_eval_bit",   32'(ifa.out_bit),   32'(e3[i]));
      chk("a_eval_idx",   32'(ifa.out_idx),   32'(v3[i]));
    end
    ifa.in_valid = 1'b0;
    tick;
    chk("a_eval_drain", 32'(ifa.out_valid), 0);

    // serial load of XOR3 (8'h69) with a gap after beat 3
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        ifa.cfg_valid = 1'b0;
        tick;
        tick;
        chk("a_gap_busy",     32'(ifa.busy),     1);
        chk("a_gap_table_ok", 32'(ifa.table_ok), 0);
        chk("a_gap_in_ready", 32'(ifa.in_ready), 0);
      end
      ifa.cfg_valid = 1'b1;
      ifa.cfg_data  = b69[i];
      #1;
      chk("a_load_cfg_ready", 32'(ifa.cfg_ready), 1);
      tick;
      chk("a_load_busy",     32'(ifa.busy),     (i < 7) ? 1 : 0);
      chk("a_load_table_ok", 32'(ifa.table_ok), (i == 7) ? 1 : 0);
    end
    ifa.cfg_valid = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_vec    = 3'b110;
    tick;
    chk("a_xor_valid", 32'(ifa.out_valid), 1);
    chk("a_xor_bit_110", 32'(ifa.out_bit), 0);
    chk("a_xor_idx_110", 32'(ifa.out_idx), 32'h6);
    ifa.in_vec = 3'b111;
    tick;
    chk("a_xor_bit_111", 32'(ifa.out_bit), 1);
    ifa.in_valid = 1'b0;
    tick;

    // reset after 5 of 8 beats restores 8'hBA
    for (int i = 0; i < 5; i++) begin
      ifa.cfg_valid = 1'b1;
      ifa.cfg_data  = 1'b1;
      tick;
    end
    ifa.cfg_valid = 1'b0;
    chk("a_part_table_ok", 32'(ifa.table_ok), 0);
    chk("a_part_busy",     32'(ifa.busy),     1);
    rst_a = 1'b1;
    tick;
    rst_a = 1'b0;
    chk("a_midrst_table_ok", 32'(ifa.table_ok), 1);
    chk("a_midrst_busy",     32'(ifa.busy),     0);
    ifa.in_valid = 1'b1;
    ifa.in_vec   = 3'b101;
    tick;
    chk("a_midrst_bit_101", 32'(ifa.out_bit), 0);
    chk("a_midrst_idx_101", 32'(ifa.out_idx), 32'h5);
    ifa.in_valid = 1'b0;
    tick;

    // sweep with out_ready toggling
    ifa.sweep_start = 1'b1;
    #1;
    chk("a_sw_start_in_ready", 32'(ifa.in_ready), 0);
    tick;
    ifa.sweep_start = 1'b0;
    chk("a_sw_busy", 32'(ifa.busy), 1);
    n = 0;
    c = 0;
    stalled  = 1'b0;
    hold_idx = '0;
    while (n < 8 && c < 64) begin
      ifa.out_ready = (c % 2 == 0);
      #1;
      chk("a_sw_in_ready",  32'(ifa.in_ready),  0);
      chk("a_sw_cfg_ready", 32'(ifa.cfg_ready), 0);
      if (stalled) chk("a_sw_hold_idx", 32'(ifa.out_idx), 32'(hold_idx));
      stalled  = ifa.out_valid && !ifa.out_ready;
      hold_idx = ifa.out_idx;
      if (ifa.out_valid && ifa.out_ready) begin
        chk("a_sw_idx", 32'(ifa.out_idx), 32'(n));
        chk("a_sw_bit", 32'(ifa.out_bit), 32'(e_sw[n]));
        n++;
      end
      tick;
      c++;
    end
    chk("a_sw_count",     32'(n),             8);
    chk("a_sw_end_busy",  32'(ifa.busy),      0);
    chk("a_sw_end_valid", 32'(ifa.out_valid), 0);
    ifa.out_ready = 1'b1;
    #1;
    chk("a_sw_end_in_ready", 32'(ifa.in_ready), 1);

    // cfg beat beats sweep_start and in_valid in the same cycle
    ifa.cfg_valid   = 1'b1;
    ifa.cfg_data    = 1'b0;
    ifa.sweep_start = 1'b1;
    ifa.in_valid    = 1'b1;
    ifa.in_vec      = 3'b000;
    #1;
    chk("a_pri_in_ready",  32'(ifa.in_ready),  0);
    chk("a_pri_cfg_ready", 32'(ifa.cfg_ready), 1);
    tick;
    ifa.cfg_valid   = 1'b0;
    ifa.sweep_start = 1'b0;
    ifa.in_valid    = 1'b0;
    chk("a_pri_busy",     32'(ifa.busy),      1);
    chk("a_pri_table_ok", 32'(ifa.table_ok),  0);
    chk("a_pri_no_eval",  32'(ifa.out_valid), 0);
    tick;
    chk("a_pri_no_sweep", 32'(ifa.out_valid), 0);
    chk("a_pri_load_cfg_ready", 32'(ifa.cfg_ready), 1);
    rst_a = 1'b1;
    tick;
    rst_a = 1'b0;

    // 4-input instance starting empty
    ifb.in_valid = 1'b1;
    ifb.in_vec   = 4'b0000;
    #1;
    chk("b_empty_in_ready", 32'(ifb.in_ready), 0);
    tick;
    chk("b_empty_no_out", 32'(ifb.out_valid), 0);
    ifb.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ifb.cfg_valid = 1'b1;
      ifb.cfg_data  = (i == 0);
      tick;
      chk("b_load_table_ok", 32'(ifb.table_ok), (i == 15) ? 1 : 0);
      if (i == 7) begin
        ifb.cfg_valid = 1'b0;
        ifb.in_valid  = 1'b1;
        #1;
        chk("b_load_in_ready", 32'(ifb.in_ready), 0);
        tick;
        chk("b_load_no_out", 32'(ifb.out_valid), 0);
        ifb.in_valid = 1'b0;
      end
    end
    ifb.cfg_valid = 1'b0;
    chk("b_loaded_busy", 32'(ifb.busy), 0);
    for (int i = 0; i < 4; i++) begin
      ifb.in_valid = 1'b1;
      ifb.in_vec   = v4[i];
      #1;
      chk("b_eval_in_ready", 32'(ifb.in_ready), 1);
      tick;
      chk("b_eval_valid", 32'(ifb.out_valid), 1);
      chk("b_eval_bit",   32'(ifb.out_bit),   32'(e4[i]));
      chk("b_eval_idx",   32'(ifb.out_idx),   32'(v4[i]));
    end
    ifb.in_valid = 1'b0;
    tick;
    chk("b_eval_drain", 32'(ifb.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lut_eval_seq.md
Name: lut_eval_seq

Overview:
- Parametrised, run-time programmable successor to the fixed 3-input truth-table gate modules.
- Holds an N_IN-input truth table in a register. The table is loaded serially or taken from a reset default.
- Evaluates input vectors through a valid/ready handshake with a registered output.
- Provides a sweep mode that emits the full truth table, index by index, for gate characterisation.

Parameters:
- N_IN, 3, number of logic inputs. Legal range 1..8. Table depth DEPTH = 2**N_IN (localparam).
- INIT_TABLE, 8'hBA (DEPTH bits wide), table value loaded at reset.
- INIT_VALID, 1, 1 = table usable immediately after reset; 0 = block waits for a serial load.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- cfg_valid  input  1  serial table bit present.
- cfg_data  input  1  table bit. Bits arrive in index order 0..DEPTH-1.
- cfg_ready  output  1  block accepts a cfg beat.
- in_valid  input  1  evaluation request.
- in_vec  input  N_IN  input vector. MSB = in1, LSB = inN.
- in_ready  output  1  evaluation request accepted.
- sweep_start  input  1  one-cycle request to emit all DEPTH entries.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_bit  output  1  truth-table output.
- out_idx  output  N_IN  input vector that produced out_bit.
- busy  output  1  state is LOAD or SWEEP.
- table_ok  output  1  a complete table is held.

Behaviour:
- Table encoding: the output for input index k is TABLE[DEPTH-1-k]. With TABLE = 8'hBA: 000->1, 001->0, 010->1, 011->1, 100->1, 101->0, 110->1, 111->0.
- Reset (synchronous, active-high, wins over all other inputs):
  - TABLE = INIT_TABLE.
  - state = READY if INIT_VALID else EMPTY.
  - table_ok = INIT_VALID.
  - out_valid = 0, out_bit = 0, out_idx = 0.
  - Load counter = 0, sweep counter = 0.
- States: EMPTY, LOAD, READY, SWEEP.
- cfg_ready = (state in {EMPTY, LOAD, READY}) && !out_valid.
- Loading:
  - The first cfg beat accepted in EMPTY or READY moves the state to LOAD. table_ok drops to 0 the next cycle.
  - Each accepted beat does TABLE = {TABLE[DEPTH-2:0], cfg_data} and increments the counter.
  - On beat number DEPTH: state goes to READY, table_ok = 1, counter = 0.
  - Gaps (cfg_valid low) are allowed in LOAD. The block stays in LOAD indefinitely.
  - Reset mid-load restores INIT_TABLE and the INIT_VALID state. A partial table is never marked valid.
- Evaluation:
  - in_ready = (state == READY) && !cfg_valid && !sweep_start && (!out_valid || out_ready).
  - On an accepted request, the next cycle has out_valid = 1, out_bit = TABLE[DEPTH-1-in_vec], out_idx = in_vec. Latency is 1 cycle.
  - Back-to-back requests reach full throughput when out_ready is held high.
  - While out_valid && !out_ready, out_bit and out_idx are held stable.
  - out_valid clears on a transfer unless a new result loads in the same cycle.
- Priority in READY, highest first: cfg_valid, then sweep_start, then in_valid. A lower-priority request sees its ready low or is ignored.
- Sweep:
  - sweep_start is honoured only in READY with cfg_valid low. It is ignored in all other states and never queued.
  - In SWEEP, each cycle where (!out_valid || out_ready) loads a result for sweep index s and increments s, for s = 0..DEPTH-1 in order.
  - After the index DEPTH-1 result transfers (out_valid && out_ready), state returns to READY and s = 0.
  - in_ready = 0 and cfg_ready = 0 throughout SWEEP.
- Wrap and overflow: the counters are N_IN+1 bits wide and are compared against DEPTH. There is no modulo wrap into a second pass.
- busy = (state == LOAD) || (state == SWEEP). busy is a registered state decode.

Test Plan:
- Reset with defaults (N_IN = 3), then apply in_vec = 3'b000, 3'b001, 3'b011, 3'b111 back-to-back with out_ready = 1 -> out_bit = 1, 0, 1, 0 on the 4 cycles after acceptance, and out_idx echoes each vector.
- Serially load bits 0,1,1,0,1,0,0,1 (XOR3 = 8'h69), then evaluate 3'b110 -> table_ok low during load and high after beat 8; out_bit = 0, and out_idx = 3'b110.
- sweep_start in READY with 8'hBA, out_ready toggling 1,0,1,0... -> out_idx steps 0..7 only on transfers, out_bit sequence 1,0,1,1,1,0,1,0, then state returns to READY and busy falls.
- Assert reset after 5 of 8 cfg beats -> TABLE = 8'hBA, table_ok = 1, and evaluating 3'b101 gives 0.
- In READY, assert cfg_valid, sweep_start and in_valid in the same cycle -> cfg beat accepted, in_ready = 0, no sweep, state = LOAD.
- Instance with N_IN = 4 and INIT_VALID = 0 -> in_ready stays 0 until 16 beats load; after loading 16'h8000, only in_vec = 4'b0000 returns 1.
